// File: rtl/pacman_pkg.sv
// Types and constants shared by the Pac-Man movement controller and the
// downstream bitmap stage.
package pacman_pkg;

  typedef enum logic [1:0] {
    UP    = 2'b00,
    DOWN  = 2'b01,
    LEFT  = 2'b10,
    RIGHT = 2'b11
  } dir_t;

  localparam int HIT_LEFT   = 3;
  localparam int HIT_TOP    = 2;
  localparam int HIT_RIGHT  = 1;
  localparam int HIT_BOTTOM = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MOVE    = 2'd1,
    BLOCKED = 2'd2
  } move_state_t;

  // Opposite directions differ only in the low bit of the encoding.
  function automatic dir_t reverse(input dir_t d);
    return dir_t'(d ^ 2'b01);
  endfunction

endpackage

// File: rtl/pacman_move_if.sv
// Frame, key, collision and sprite-position signals of the Pac-Man movement
// controller; the controller takes the slave side.
interface pacman_move_if;
  import pacman_pkg::*;

  logic        startOfFrame;
  logic        enable;
  logic        key_up;
  logic        key_down;
  logic        key_left;
  logic        key_right;
  logic        collision;
  logic [3:0]  HitEdgeCode;
  logic [10:0] topLeftX;
  logic [10:0] topLeftY;
  dir_t        direction;
  logic        moving;

  modport master (
    output startOfFrame, enable, key_up, key_down, key_left, key_right,
           collision, HitEdgeCode,
    input  topLeftX, topLeftY, direction, moving
  );

  modport slave (
    input  startOfFrame, enable, key_up, key_down, key_left, key_right,
           collision, HitEdgeCode,
    output topLeftX, topLeftY, direction, moving
  );

endinterface

// File: rtl/pacman_move.sv
// Per-frame Pac-Man movement controller: turns keys and wall hits into a
// sprite top-left position and facing direction, updated once per frame.
module pacman_move
  import pacman_pkg::*;
#(
  parameter int INITIAL_X = 304,
  parameter int INITIAL_Y = 224,
  parameter int SPEED     = 2,
  parameter int GRID_BITS = 5,
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 608
) (
  input logic          clk,
  input logic          reset,
  pacman_move_if.slave bus
);

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
  } pos_t;

  localparam logic [10:0] SPD         = 11'(SPEED);
  localparam logic [10:0] WRAP_LO     = 11'(X_MIN);
  localparam logic [10:0] WRAP_HI     = 11'(X_MAX);
  localparam logic [11:0] LEFT_LIMIT  = 12'(X_MIN + SPEED);
  localparam logic [11:0] RIGHT_LIMIT = 12'(X_MAX);
  localparam pos_t        RESET_POS   = '{x: 11'(INITIAL_X), y: 11'(INITIAL_Y)};

  function automatic dir_t encode_keys(input logic up, input logic down,
                                       input logic left, input logic right);
    dir_t d;
    d = RIGHT;
    if (up)         d = UP;
    else if (down)  d = DOWN;
    else if (left)  d = LEFT;
    else if (right) d = RIGHT;
    return d;
  endfunction

  // A left step that would drop below X_MIN (including unsigned underflow)
  // wraps to X_MAX; the comparison is done before subtracting.
  function automatic pos_t step(input dir_t d, input pos_t p);
    pos_t n;
    logic [11:0] right_sum;
    n = p;
    right_sum = {1'b0, p.x} + 12'(SPEED);
    case (d)
      UP:    n.y = p.y - SPD;
      DOWN:  n.y = p.y + SPD;
      LEFT:  n.x = ({1'b0, p.x} < LEFT_LIMIT) ? WRAP_HI : (p.x - SPD);
      RIGHT: n.x = (right_sum > RIGHT_LIMIT) ? WRAP_LO : right_sum[10:0];
    endcase
    return n;
  endfunction

  function automatic logic relevant_hit(input dir_t d, input logic [3:0] h);
    logic r;
    r = 1'b0;
    case (d)
      UP:    r = h[HIT_TOP];
      DOWN:  r = h[HIT_BOTTOM];
      LEFT:  r = h[HIT_LEFT];
      RIGHT: r = h[HIT_RIGHT];
    endcase
    return r;
  endfunction

  move_state_t state_q, state_d;
  dir_t        dir_q, dir_d, pending_q, key_dir, pend_eff, turn_dir;
  pos_t        pos_q, pos_d;
  logic [3:0]  acc_q, hit_eff;
  logic        seen_q, sof_q, moving_q;
  logic        any_key, decide, aligned;

  assign any_key  = bus.key_up | bus.key_down | bus.key_left | bus.key_right;
  assign key_dir  = encode_keys(bus.key_up, bus.key_down, bus.key_left, bus.key_right);
  assign pend_eff = any_key ? key_dir : pending_q;
  assign hit_eff  = acc_q | (bus.collision ? bus.HitEdgeCode : 4'b0000);
  assign decide   = bus.startOfFrame & ~sof_q & bus.enable;
  assign aligned  = (pos_q.x[GRID_BITS-1:0] == '0) && (pos_q.y[GRID_BITS-1:0] == '0);

  // Only the rising cycle of startOfFrame decides, so a wide pulse still
  // yields a single step. Keys are sampled even while the game is paused.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= RIGHT;
      seen_q    <= 1'b0;
      sof_q     <= 1'b0;
      acc_q     <= 4'b0000;
    end else begin
      sof_q <= bus.startOfFrame;
      if (any_key) begin
        pending_q <= key_dir;
        seen_q    <= 1'b1;
      end
      if (decide)
        acc_q <= 4'b0000;
      else if (bus.enable && bus.collision)
        acc_q <= acc_q | bus.HitEdgeCode;
    end
  end

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    pos_d    = pos_q;
    turn_dir = dir_q;
    if (decide) begin
      case (state_q)
        IDLE: begin
          if (seen_q || any_key) begin
            dir_d   = pend_eff;
            pos_d   = step(pend_eff, pos_q);
            state_d = MOVE;
          end
        end
        MOVE: begin
          if (relevant_hit(dir_q, hit_eff)) begin
            pos_d   = step(reverse(dir_q), pos_q);
            state_d = BLOCKED;
          end else begin
            // Reversal is always legal; a perpendicular turn must wait for a tile corner.
            if (pend_eff == reverse(dir_q))
              turn_dir = pend_eff;
            else if (pend_eff != dir_q && aligned)
              turn_dir = pend_eff;
            dir_d = turn_dir;
            pos_d = step(turn_dir, pos_q);
          end
        end
        BLOCKED: begin
          if (pend_eff != dir_q) begin
            dir_d   = pend_eff;
            pos_d   = step(pend_eff, pos_q);
            state_d = MOVE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      dir_q    <= RIGHT;
      pos_q    <= RESET_POS;
      moving_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      pos_q    <= pos_d;
      moving_q <= (state_d == MOVE);
    end
  end

  assign bus.topLeftX  = pos_q.x;
  assign bus.topLeftY  = pos_q.y;
  assign bus.direction = dir_q;
  assign bus.moving    = moving_q;

endmodule

// File: tb/tb_pacman_move.sv
// Self-checking bench for pacman_move: directed scenarios plus randomized
// frames compared against a behavioural movement model.
module tb_pacman_move;
  import pacman_pkg::*;

  localparam int XMIN = 0;
  localparam int XMAX = 608;
  localparam int TILE = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pacman_move_if bus();
  pacman_move dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int failures = 0;

  // Model: position as plain integers, direction as 0..3 with movement vectors.
  int m_x, m_y, m_dir, m_pend;
  bit m_started, m_blocked, m_seen, m_prev_sof;
  logic [3:0] m_acc;
  int dxs[4]      = '{0, 0, -2, 2};
  int dys[4]      = '{-2, 2, 0, 0};
  int opposite[4] = '{1, 0, 3, 2};
  int hit_bit[4]  = '{HIT_TOP, HIT_BOTTOM, HIT_LEFT, HIT_RIGHT};

  function automatic void model_reset();
    m_x = 304; m_y = 224; m_dir = 3; m_pend = 3;
    m_started = 0; m_blocked = 0; m_seen = 0; m_prev_sof = 0; m_acc = 4'b0;
  endfunction

  function automatic void model_move(int d);
    int nx;
    nx = m_x + dxs[d];
    if (nx < XMIN) nx = XMAX;
    else if (nx > XMAX) nx = XMIN;
    m_x = nx;
    m_y = (m_y + dys[d]) & 2047;
  endfunction

  function automatic void model_clock();
    bit any_k, seen;
    int kd, pend;
    logic [3:0] hit;
    any_k = bus.key_up | bus.key_down | bus.key_left | bus.key_right;
    kd = bus.key_up ? 0 : bus.key_down ? 1 : bus.key_left ? 2 : 3;
    pend = any_k ? kd : m_pend;
    seen = m_seen || any_k;
    if (bus.enable && bus.startOfFrame && !m_prev_sof) begin
      hit = m_acc | (bus.collision ? bus.HitEdgeCode : 4'b0);
      if (!m_started) begin
        if (seen) begin m_dir = pend; model_move(pend); m_started = 1; end
      end else if (m_blocked) begin
        if (pend != m_dir) begin m_dir = pend; model_move(pend); m_blocked = 0; end
      end else if (hit[hit_bit[m_dir]]) begin
        model_move(opposite[m_dir]);
        m_blocked = 1;
      end else begin
        if (pend == opposite[m_dir] ||
            (pend != m_dir && m_x % TILE == 0 && m_y % TILE == 0))
          m_dir = pend;
        model_move(m_dir);
      end
      m_acc = 4'b0;
    end else if (bus.enable && bus.collision) begin
      m_acc = m_acc | bus.HitEdgeCode;
    end
    if (any_k) m_pend = kd;
    m_seen = seen;
    m_prev_sof = bus.startOfFrame;
  endfunction

  function automatic logic [24:0] dut_vec();
    return {bus.topLeftX, bus.topLeftY, bus.direction, bus.moving};
  endfunction

  function automatic logic [24:0] model_vec();
    return {11'(m_x), 11'(m_y), 2'(m_dir), m_started & ~m_blocked};
  endfunction

  function automatic logic [24:0] want(int x, int y, int d, bit mv);
    return {11'(x), 11'(y), 2'(d), mv};
  endfunction

  function automatic string fmt(logic [24:0] v);
    return $sformatf("x=%0d y=%0d dir=%0d moving=%0b", v[24:14], v[13:3], v[2:1], v[0]);
  endfunction

  task automatic idle_inputs();
    bus.startOfFrame = 0; bus.enable = 1;
    bus.key_up = 0; bus.key_down = 0; bus.key_left = 0; bus.key_right = 0;
    bus.collision = 0; bus.HitEdgeCode = 4'b0;
  endtask

  task automatic tick();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    bus.startOfFrame = 1; tick();
    bus.startOfFrame = 0; tick(); tick(); tick();
  endtask

  task automatic press(input int d);
    bus.key_up = (d == 0); bus.key_down = (d == 1);
    bus.key_left = (d == 2); bus.key_right = (d == 3);
    tick();
    bus.key_up = 0; bus.key_down = 0; bus.key_left = 0; bus.key_right = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dut_vec() !== want(304, 224, 3, 0)) begin
      failures++;
      $display("[TB] FAIL reset_state got %s want %s", fmt(dut_vec()), fmt(want(304, 224, 3, 0)));
    end
    for (int i = 0; i < 5; i++) begin
      frame();
      checks++;
      if (dut_vec() !== want(304, 224, 3, 0)) begin
        failures++;
        $display("[TB] FAIL idle_no_keys frame %0d got %s want %s", i, fmt(dut_vec()), fmt(want(304, 224, 3, 0)));
      end
    end
  endtask

  task automatic test_left_steps();
    do_reset();
    press(2);
    tick();
    for (int k = 1; k <= 3; k++) begin
      frame();
      checks++;
      if (dut_vec() !== want(304 - 2 * k, 224, 2, 1)) begin
        failures++;
        $display("[TB] FAIL left_step %0d got %s want %s", k, fmt(dut_vec()), fmt(want(304 - 2 * k, 224, 2, 1)));
      end
    end
  endtask

  task automatic test_turns();
    do_reset();
    press(3);
    repeat (8) frame();
    press(0);
    frame();
    checks++;
    if (dut_vec() !== want(320, 222, 0, 1)) begin
      failures++;
      $display("[TB] FAIL aligned_turn got %s want %s", fmt(dut_vec()), fmt(want(320, 222, 0, 1)));
    end
    do_reset();
    press(3);
    repeat (9) frame();
    press(0);
    frame();
    checks++;
    if (dut_vec() !== want(324, 224, 3, 1)) begin
      failures++;
      $display("[TB] FAIL deferred_turn got %s want %s", fmt(dut_vec()), fmt(want(324, 224, 3, 1)));
    end
    for (int i = 0; i < 20 && bus.direction == RIGHT; i++) begin
      frame();
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++;
        $display("[TB] FAIL deferred_walk got %s want %s", fmt(dut_vec()), fmt(model_vec()));
      end
    end
    checks++;
    if (dut_vec() !== want(352, 222, 0, 1)) begin
      failures++;
      $display("[TB] FAIL turn_at_corner got %s want %s", fmt(dut_vec()), fmt(want(352, 222, 0, 1)));
    end
  endtask

  task automatic test_blocked();
    do_reset();
    press(3);
    repeat (48) frame();
    bus.collision = 1; bus.HitEdgeCode = 4'b0010;
    tick();
    bus.collision = 0; bus.HitEdgeCode = 4'b0;
    frame();
    checks++;
    if (dut_vec() !== want(398, 224, 3, 0)) begin
      failures++;
      $display("[TB] FAIL backoff got %s want %s", fmt(dut_vec()), fmt(want(398, 224, 3, 0)));
    end
    repeat (2) frame();
    checks++;
    if (dut_vec() !== want(398, 224, 3, 0)) begin
      failures++;
      $display("[TB] FAIL blocked_hold got %s want %s", fmt(dut_vec()), fmt(want(398, 224, 3, 0)));
    end
    press(1);
    frame();
    checks++;
    if (dut_vec() !== want(398, 226, 1, 1)) begin
      failures++;
      $display("[TB] FAIL unblock got %s want %s", fmt(dut_vec()), fmt(want(398, 226, 1, 1)));
    end
    bus.collision = 1; bus.HitEdgeCode = 4'b0001; bus.startOfFrame = 1;
    tick();
    bus.collision = 0; bus.HitEdgeCode = 4'b0; bus.startOfFrame = 0;
    tick();
    checks++;
    if (dut_vec() !== want(398, 224, 1, 0)) begin
      failures++;
      $display("[TB] FAIL coincident_hit got %s want %s", fmt(dut_vec()), fmt(want(398, 224, 1, 0)));
    end
  endtask

  task automatic test_wrap();
    do_reset();
    press(2);
    repeat (152) frame();
    checks++;
    if (dut_vec() !== want(0, 224, 2, 1)) begin
      failures++;
      $display("[TB] FAIL reach_left_edge got %s want %s", fmt(dut_vec()), fmt(want(0, 224, 2, 1)));
    end
    frame();
    checks++;
    if (dut_vec() !== want(608, 224, 2, 1)) begin
      failures++;
      $display("[TB] FAIL wrap_left got %s want %s", fmt(dut_vec()), fmt(want(608, 224, 2, 1)));
    end
    press(3);
    frame();
    checks++;
    if (dut_vec() !== want(0, 224, 3, 1)) begin
      failures++;
      $display("[TB] FAIL wrap_right got %s want %s", fmt(dut_vec()), fmt(want(0, 224, 3, 1)));
    end
  endtask

  task automatic test_enable_and_edges();
    do_reset();
    bus.enable = 0;
    press(1);
    repeat (3) frame();
    checks++;
    if (dut_vec() !== want(304, 224, 3, 0)) begin
      failures++;
      $display("[TB] FAIL paused_hold got %s want %s", fmt(dut_vec()), fmt(want(304, 224, 3, 0)));
    end
    bus.enable = 1;
    frame();
    checks++;
    if (dut_vec() !== want(304, 226, 1, 1)) begin
      failures++;
      $display("[TB] FAIL pending_while_paused got %s want %s", fmt(dut_vec()), fmt(want(304, 226, 1, 1)));
    end
    do_reset();
    bus.key_up = 1; bus.startOfFrame = 1;
    tick();
    bus.key_up = 0; bus.startOfFrame = 0;
    tick();
    checks++;
    if (dut_vec() !== want(304, 222, 0, 1)) begin
      failures++;
      $display("[TB] FAIL key_on_sof got %s want %s", fmt(dut_vec()), fmt(want(304, 222, 0, 1)));
    end
    do_reset();
    press(2);
    bus.startOfFrame = 1;
    repeat (3) tick();
    bus.startOfFrame = 0;
    tick();
    checks++;
    if (dut_vec() !== want(302, 224, 2, 1)) begin
      failures++;
      $display("[TB] FAIL wide_sof got %s want %s", fmt(dut_vec()), fmt(want(302, 224, 2, 1)));
    end
  endtask

  task automatic test_midframe_reset();
    do_reset();
    press(3);
    repeat (48) frame();
    bus.startOfFrame = 1; tick();
    bus.startOfFrame = 0; tick();
    #2;
    reset = 1;
    #1;
    checks++;
    if (dut_vec() !== want(304, 224, 3, 0)) begin
      failures++;
      $display("[TB] FAIL async_reset got %s want %s", fmt(dut_vec()), fmt(want(304, 224, 3, 0)));
    end
    @(posedge clk);
    #1;
    reset = 0;
    model_reset();
    frame();
    checks++;
    if (dut_vec() !== want(304, 224, 3, 0)) begin
      failures++;
      $display("[TB] FAIL idle_after_reset got %s want %s", fmt(dut_vec()), fmt(want(304, 224, 3, 0)));
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bus.key_up       = ($urandom_range(0, 19) == 0);
      bus.key_down     = ($urandom_range(0, 19) == 0);
      bus.key_left     = ($urandom_range(0, 19) == 0);
      bus.key_right    = ($urandom_range(0, 19) == 0);
      bus.collision    = ($urandom_range(0, 11) == 0);
      bus.HitEdgeCode  = 4'($urandom_range(0, 15));
      bus.startOfFrame = ($urandom_range(0, 4) == 0);
      bus.enable       = ($urandom_range(0, 15) != 0);
      tick();
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++;
        $display("[TB] FAIL random cycle %0d got %s want %s", i, fmt(dut_vec()), fmt(model_vec()));
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    model_reset();
    test_reset();
    test_left_steps();
    test_turns();
    test_blocked();
    test_wrap();
    test_enable_and_edges();
    test_midframe_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
